// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader.
// Holds the loader frame FSM encoding, the UART receiver state encoding,
// the 8N1 frame constants and a small word-index to byte-address helper.
package uart_boot_loader_pkg;

  // 8N1 framing: eight data bits, LSB first, one stop bit, no parity.
  localparam int DATA_BITS = 8;
  localparam bit LSB_FIRST = 1'b1;
  localparam int STOP_BITS = 1;

  // Loader frame FSM: two length bytes, then payload words.
  typedef enum logic [2:0] {
    LEN0  = 3'd0,
    LEN1  = 3'd1,
    DATA  = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } ldr_state_e;

  // Byte receiver bit-phase FSM.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_BITS  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Word index to word-aligned byte address.
  function automatic logic [31:0] word_to_byte_addr(input logic [15:0] idx);
    return {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/uart_boot_loader_uart_rx.sv
// uart_rx: 8N1 UART byte receiver.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   rx         - raw serial line, idle high
//   rx_byte    - last assembled byte (valid while byte_valid=1)
//   byte_valid - one-cycle strobe on a good stop-bit sample
//   frame_err  - one-cycle strobe on a stop-bit sample of 0
// The strobes are decoded from the stop-bit sampling cycle so that the
// loader can register its write strobe on that very edge.
module uart_rx
  import uart_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             prev_r;
  rx_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             stop_tick_s;

  // Synchronizer, edge history and bit-phase state machine.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      prev_r    <= 1'b1;
      state_r   <= RX_IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      case (state_r)
        RX_IDLE: begin
          cnt_r     <= '0;
          bit_idx_r <= 3'd0;
          // Only a genuine high-to-low transition starts a frame.
          if (prev_r && !sync2_r) begin
            state_r <= RX_START;
          end else begin
            state_r <= RX_IDLE;
          end
        end
        RX_START: begin
          if (cnt_r == HALF_M1) begin
            cnt_r <= '0;
            // A high level at mid start bit was a glitch: drop it silently.
            if (!sync2_r) begin
              state_r <= RX_BITS;
            end else begin
              state_r <= RX_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        RX_BITS: begin
          if (cnt_r == FULL_M1) begin
            cnt_r     <= '0;
            shift_r   <= {sync2_r, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == LAST_BIT) begin
              state_r <= RX_STOP;
            end else begin
              state_r <= RX_BITS;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_r == FULL_M1) begin
            cnt_r   <= '0;
            state_r <= RX_IDLE;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= RX_IDLE;
        end
      endcase
    end
  end

  // Stop-bit sample decode into byte/framing strobes.
  always_comb begin
    stop_tick_s = 1'b0;
    byte_valid  = 1'b0;
    frame_err   = 1'b0;
    rx_byte     = shift_r;
    if (state_r == RX_STOP && cnt_r == FULL_M1) begin
      stop_tick_s = 1'b1;
    end else begin
      stop_tick_s = 1'b0;
    end
    byte_valid = stop_tick_s & sync2_r;
    frame_err  = stop_tick_s & ~sync2_r;
  end

endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a length-prefixed image over UART and writes it
// into instruction memory, holding the core in reset until the load ends.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   rx         - UART serial line (8N1, LSB first)
//   imem_we    - one-cycle instruction-memory write strobe
//   imem_addr  - word-aligned byte address (0 when imem_we=0)
//   imem_wdata - little-endian assembled word (0 when imem_we=0)
//   core_rst   - active-high core reset, released after a complete load
//   busy       - load in progress
//   err        - sticky error (framing error or oversize length)
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        busy,
  output logic        err
);

  localparam int          MAX_WORDS   = 2 ** ADDR_W;
  localparam logic [16:0] MAX_WORDS_L = 17'(MAX_WORDS);

  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        frame_err;
  ldr_state_e  state_r;
  logic [15:0] count_r;
  logic [15:0] word_idx_r;
  logic [1:0]  byte_cnt_r;
  logic [23:0] word_buf_r;
  logic [15:0] len_s;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  // Full word count as it stands when the second length byte arrives.
  always_comb begin
    len_s = {rx_byte, count_r[7:0]};
  end

  // Loader frame FSM with registered memory-port and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= LEN0;
      count_r    <= 16'd0;
      word_idx_r <= 16'd0;
      byte_cnt_r <= 2'd0;
      word_buf_r <= 24'd0;
      imem_we    <= 1'b0;
      imem_addr  <= 32'd0;
      imem_wdata <= 32'd0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we    <= 1'b0;
      imem_addr  <= 32'd0;
      imem_wdata <= 32'd0;
      case (state_r)
        LEN0: begin
          if (frame_err) begin
            state_r <= ERROR;
            err     <= 1'b1;
            busy    <= 1'b0;
          end else if (byte_valid) begin
            count_r[7:0] <= rx_byte;
            busy         <= 1'b1;
            state_r      <= LEN1;
          end else begin
            state_r <= LEN0;
          end
        end
        LEN1: begin
          if (frame_err) begin
            state_r <= ERROR;
            err     <= 1'b1;
            busy    <= 1'b0;
          end else if (byte_valid) begin
            count_r <= len_s;
            if ({1'b0, len_s} > MAX_WORDS_L) begin
              state_r <= ERROR;
              err     <= 1'b1;
              busy    <= 1'b0;
            end else if (len_s == 16'd0) begin
              // Empty image: release the core right away.
              state_r  <= DONE;
              core_rst <= 1'b0;
              busy     <= 1'b0;
            end else begin
              state_r <= DATA;
            end
          end else begin
            state_r <= LEN1;
          end
        end
        DATA: begin
          if (frame_err) begin
            state_r <= ERROR;
            err     <= 1'b1;
            busy    <= 1'b0;
          end else if (byte_valid) begin
            if (byte_cnt_r == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_to_byte_addr(word_idx_r);
              imem_wdata <= {rx_byte, word_buf_r};
              word_idx_r <= word_idx_r + 16'd1;
              byte_cnt_r <= 2'd0;
              // Last word written: DONE drops core_rst on the next edge.
              if (word_idx_r == count_r - 16'd1) begin
                state_r <= DONE;
                busy    <= 1'b0;
              end else begin
                state_r <= DATA;
              end
            end else begin
              case (byte_cnt_r)
                2'd0:    word_buf_r[7:0]   <= rx_byte;
                2'd1:    word_buf_r[15:8]  <= rx_byte;
                2'd2:    word_buf_r[23:16] <= rx_byte;
                default: word_buf_r        <= word_buf_r;
              endcase
              byte_cnt_r <= byte_cnt_r + 2'd1;
            end
          end else begin
            state_r <= DATA;
          end
        end
        DONE: begin
          core_rst <= 1'b0;
          busy     <= 1'b0;
        end
        ERROR: begin
          err      <= 1'b1;
          core_rst <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          state_r <= LEN0;
        end
      endcase
    end
  end

endmodule
